// File: rtl/dprintf_rr_arb_4.sv
// dprintf_rr_arb_4: round-robin arbiter; four dprintf requesters (req_N__*/ack_N) share one engine (req__*/ack), busy while a grant awaits ack
module dprintf_rr_arb_4 (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        req_0__valid,
    input  logic [15:0] req_0__address,
    input  logic [63:0] req_0__data_0,
    input  logic [63:0] req_0__data_1,
    input  logic [63:0] req_0__data_2,
    input  logic [63:0] req_0__data_3,
    input  logic        req_1__valid,
    input  logic [15:0] req_1__address,
    input  logic [63:0] req_1__data_0,
    input  logic [63:0] req_1__data_1,
    input  logic [63:0] req_1__data_2,
    input  logic [63:0] req_1__data_3,
    input  logic        req_2__valid,
    input  logic [15:0] req_2__address,
    input  logic [63:0] req_2__data_0,
    input  logic [63:0] req_2__data_1,
    input  logic [63:0] req_2__data_2,
    input  logic [63:0] req_2__data_3,
    input  logic        req_3__valid,
    input  logic [15:0] req_3__address,
    input  logic [63:0] req_3__data_0,
    input  logic [63:0] req_3__data_1,
    input  logic [63:0] req_3__data_2,
    input  logic [63:0] req_3__data_3,
    output logic        ack_0,
    output logic        ack_1,
    output logic        ack_2,
    output logic        ack_3,
    output logic        req__valid,
    output logic [15:0] req__address,
    output logic [63:0] req__data_0,
    output logic [63:0] req__data_1,
    output logic [63:0] req__data_2,
    output logic [63:0] req__data_3,
    input  logic        ack,
    output logic        busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [1:0] last_grant, sel;
    logic found;
    logic [3:0] v, ack_r;
    logic [271:0] pk [4];
    logic [271:0] out;
    assign v = {req_3__valid, req_2__valid, req_1__valid, req_0__valid};
    assign pk[0] = {req_0__address, req_0__data_3, req_0__data_2, req_0__data_1, req_0__data_0};
    assign pk[1] = {req_1__address, req_1__data_3, req_1__data_2, req_1__data_1, req_1__data_0};
    assign pk[2] = {req_2__address, req_2__data_3, req_2__data_2, req_2__data_1, req_2__data_0};
    assign pk[3] = {req_3__address, req_3__data_3, req_3__data_2, req_3__data_1, req_3__data_0};
    assign {req__address, req__data_3, req__data_2, req__data_1, req__data_0} = out;
    assign {ack_3, ack_2, ack_1, ack_0} = ack_r;
    assign busy = state == BUSY;
    // scan farthest-first so the nearest valid port after last_grant wins
    always_comb begin
        found = 1'b0;
        sel = 2'd0;
        for (int i = 4; i >= 1; i--)
            if (v[last_grant + 2'(i)]) begin
                found = 1'b1;
                sel = last_grant + 2'(i);
            end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            last_grant <= 2'd3;
            ack_r <= '0;
            req__valid <= 1'b0;
            out <= '0;
        end else if (clk__enable) begin
            if (state == IDLE) begin
                ack_r <= found ? 4'b0001 << sel : 4'b0000;
                if (found) begin
                    state <= BUSY;
                    last_grant <= sel;
                    req__valid <= 1'b1;
                    out <= pk[sel];
                end
            end else begin
                ack_r <= '0;
                if (ack) begin
                    state <= IDLE;
                    req__valid <= 1'b0;
                end
            end
        end
endmodule

// File: tb/tb_dprintf_rr_arb_4.sv
// tb_dprintf_rr_arb_4: directed table and sequence checks for dprintf_rr_arb_4
module tb_dprintf_rr_arb_4;
    logic clk = 1'b0, clk__enable = 1'b1, reset_n = 1'b0, ack = 1'b0;
    logic [3:0] v = '0;
    logic [15:0] a [4];
    logic [63:0] d [4][4];
    logic ack_0, ack_1, ack_2, ack_3, req__valid, busy;
    logic [15:0] req__address;
    logic [63:0] req__data_0, req__data_1, req__data_2, req__data_3;
    wire [3:0] ack_n = {ack_3, ack_2, ack_1, ack_0};
    wire [271:0] out = {req__address, req__data_3, req__data_2, req__data_1, req__data_0};
    int checks = 0, errors = 0;
    logic [271:0] snap;
    logic [63:0] new_d0;
    typedef struct {
        logic [3:0] v;
        logic eack;
        logic [3:0] xack;
        logic xval;
        logic [15:0] xaddr;
        logic xbusy;
    } vec_t;
    vec_t tbl [17];
    always #5 clk = ~clk;
    dprintf_rr_arb_4 dut (
        .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n),
        .req_0__valid(v[0]), .req_0__address(a[0]),
        .req_0__data_0(d[0][0]), .req_0__data_1(d[0][1]), .req_0__data_2(d[0][2]), .req_0__data_3(d[0][3]),
        .req_1__valid(v[1]), .req_1__address(a[1]),
        .req_1__data_0(d[1][0]), .req_1__data_1(d[1][1]), .req_1__data_2(d[1][2]), .req_1__data_3(d[1][3]),
        .req_2__valid(v[2]), .req_2__address(a[2]),
        .req_2__data_0(d[2][0]), .req_2__data_1(d[2][1]), .req_2__data_2(d[2][2]), .req_2__data_3(d[2][3]),
        .req_3__valid(v[3]), .req_3__address(a[3]),
        .req_3__data_0(d[3][0]), .req_3__data_1(d[3][1]), .req_3__data_2(d[3][2]), .req_3__data_3(d[3][3]),
        .ack_0(ack_0), .ack_1(ack_1), .ack_2(ack_2), .ack_3(ack_3),
        .req__valid(req__valid), .req__address(req__address),
        .req__data_0(req__data_0), .req__data_1(req__data_1),
        .req__data_2(req__data_2), .req__data_3(req__data_3),
        .ack(ack), .busy(busy)
    );
    task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask
    function automatic logic [271:0] pk(input int p);
        return {a[p], d[p][3], d[p][2], d[p][1], d[p][0]};
    endfunction
    initial begin
        for (int i = 0; i < 4; i++) begin
            a[i] = {4'(i + 1), 12'h010};
            for (int j = 0; j < 4; j++) d[i][j] = {32'hd000_0000, 16'(i), 16'(j)};
        end
        d[2][0] = 64'h22ff000000000000;
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 16'h1010, 1'b1};
        tbl[1]  = '{4'b1110, 1'b1, 4'b0000, 1'b0, 16'h1010, 1'b0};
        tbl[2]  = '{4'b1110, 1'b0, 4'b0010, 1'b1, 16'h2010, 1'b1};
        tbl[3]  = '{4'b1100, 1'b1, 4'b0000, 1'b0, 16'h2010, 1'b0};
        tbl[4]  = '{4'b1100, 1'b0, 4'b0100, 1'b1, 16'h3010, 1'b1};
        tbl[5]  = '{4'b1000, 1'b1, 4'b0000, 1'b0, 16'h3010, 1'b0};
        tbl[6]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 16'h4010, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h4010, 1'b0};
        tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 16'h2010, 1'b1};
        tbl[9]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 16'h2010, 1'b0};
        tbl[10] = '{4'b1010, 1'b0, 4'b1000, 1'b1, 16'h4010, 1'b1};
        tbl[11] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 16'h4010, 1'b0};
        tbl[12] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 16'h2010, 1'b1};
        tbl[13] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 16'h2010, 1'b0};
        tbl[14] = '{4'b1010, 1'b0, 4'b1000, 1'b1, 16'h4010, 1'b1};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h4010, 1'b0};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h4010, 1'b0};
        repeat (2) step();
        chk("reset_ctl", {ack_n, req__valid, busy}, '0);
        chk("reset_out", out, '0);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            v = tbl[i].v;
            ack = tbl[i].eack;
            step();
            chk($sformatf("vec%0d", i), {ack_n, req__valid, req__address, busy},
                {tbl[i].xack, tbl[i].xval, tbl[i].xaddr, tbl[i].xbusy});
        end
        ack = 1'b0;
        v = 4'b0100;
        step();
        chk("p2_grant", {ack_n, req__valid, busy}, {4'b0100, 1'b1, 1'b1});
        chk("p2_data", out, {16'h3010, d[2][3], d[2][2], d[2][1], 64'h22ff000000000000});
        v = 4'b0000;
        ack = 1'b1;
        step();
        chk("p2_done", {ack_n, req__valid, busy}, {4'b0000, 1'b0, 1'b0});
        ack = 1'b0;
        v = 4'b0001;
        step();
        snap = pk(0);
        chk("dly_grant", {ack_n, req__valid}, {4'b0001, 1'b1});
        chk("dly_data", out, snap);
        new_d0 = 64'h0123456789abcdef;
        d[0][0] = new_d0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("dly_hold%0d", k), out, snap);
            chk($sformatf("dly_ctl%0d", k), {ack_n, req__valid, busy}, {4'b0000, 1'b1, 1'b1});
        end
        ack = 1'b1;
        step();
        chk("dly_done", {req__valid, busy}, 2'b00);
        ack = 1'b0;
        step();
        chk("dly_regrant", {ack_n, req__data_0}, {4'b0001, new_d0});
        v = 4'b0000;
        ack = 1'b1;
        step();
        ack = 1'b0;
        v = 4'b1000;
        step();
        chk("rst_p3", {ack_n, req__address}, {4'b1000, 16'h4010});
        v = 4'b0010;
        step();
        chk("rst_busy", {ack_n, busy}, {4'b0000, 1'b1});
        reset_n = 1'b0;
        #1;
        chk("rst_async", {ack_n, req__valid, busy}, '0);
        chk("rst_out", out, '0);
        step();
        reset_n = 1'b1;
        step();
        chk("rst_p1", {ack_n, req__valid, req__address}, {4'b0010, 1'b1, 16'h2010});
        chk("rst_last", 272'(dut.last_grant), 272'(2'd1));
        v = 4'b0000;
        ack = 1'b1;
        step();
        ack = 1'b0;
        v = 4'b0100;
        step();
        chk("en_pulse", ack_n, 4'b0100);
        clk__enable = 1'b0;
        v = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("en_hold%0d", k), ack_n, 4'b0100);
        end
        clk__enable = 1'b1;
        step();
        chk("en_drop", {ack_n, req__valid}, {4'b0000, 1'b1});
        ack = 1'b1;
        step();
        chk("en_done", {req__valid, busy}, 2'b00);
        ack = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dprintf_rr_arb_4.md
# dprintf_rr_arb_4

Four-port round-robin arbiter that shares one dprintf engine between four debug-print requesters. Replaces trees of fixed-priority two-input muxes with one block that has bounded, fair latency. Each requester presents a 4-word dprintf request (address plus data_0..data_3). The arbiter registers the granted request, acknowledges that requester, and holds the request toward the dprintf engine until the engine acknowledges it.

## Interface
- No parameters; always exactly four requesters, each with a full 4-word request (narrower requesters tie unused data words to 64'hffffffffffffffff).
- clk  in  1  clock, rising edge
- clk__enable  in  1  clock enable; state advances only when high
- reset_n  in  1  reset, asynchronous, active-low
- req_N__valid  in  1  request N valid, N=0..3
- req_N__address  in  16  request N dprintf address
- req_N__data_0..req_N__data_3  in  64 each  request N data words
- ack_N  out  1  one-cycle pulse: request N captured, N=0..3
- req__valid  out  1  granted request valid toward dprintf engine
- req__address  out  16  granted address
- req__data_0..req__data_3  out  64 each  granted data words
- ack  in  1  dprintf engine accepted req__ (engine's dprintf_ack)
- busy  out  1  high while a granted request awaits engine ack

## Operation
- Two states: IDLE, BUSY. Priority pointer last_grant[1:0].
- IDLE, some req_N__valid high:
  - Pick the first valid port in the order last_grant+1, +2, +3, +0 (mod 4).
  - Register its address and data_0..3 into req__*.
  - Set req__valid=1 and ack_N=1 for that port only, and last_grant=N.
  - Go to BUSY.
- IDLE, no valid: outputs hold; req__valid=0; all ack_N=0.
- BUSY:
  - ack_N forced to 0 after its single-cycle pulse.
  - req__* held stable, and input valids ignored.
  - On ack=1: req__valid=0 next cycle and state goes to IDLE.
- Inputs are sampled only on the grant edge. Later changes to a requester's data have no effect on req__*.
- Requester contract:
  - Hold valid and data stable until its ack_N is seen high.
  - Drop valid, or present a new request, in the cycle after ack_N.
- A requester whose valid falls before it is granted is simply not granted. No error is flagged.
- ack while in IDLE is ignored.
- busy equals (state==BUSY).
- clk__enable low: all registers hold, including the ack_N pulse, which therefore stretches across the disabled cycles.

## Timing
- Reset values:
  - state=IDLE, last_grant=3 (port 0 has first priority).
  - req__valid=0, req__address=0, req__data_0..3=0.
  - all ack_N=0, busy=0.
- Grant latency: valid seen in IDLE at edge k gives req__valid and ack_N high from edge k.
- ack_N is registered and lasts exactly one enabled cycle.
- Engine ack at edge m drops req__valid from edge m. The arbiter is IDLE at m and can grant again at edge m+1.
- Maximum throughput: one request per 2 cycles. The earliest engine ack is the first cycle req__valid is high.
- The granted requester's valid is already low when the arbiter next samples in IDLE, so there is no double grant.
- Worst-case wait for a continuously-valid requester: 3 other grants.
- Reset mid-BUSY:
  - All outputs return to reset values immediately (asynchronous).
  - The in-flight request is lost toward the engine.
  - Un-acked requesters keep valid high and are re-arbitrated after reset with port 0 first.

## Test plan
- Port 2 alone, address 16'h3010, data_0=64'h22ff000000000000; engine acks on the first cycle.
  - Required: req__valid=1 with address 16'h3010 one edge after sampling.
  - Required: ack_2 high exactly 1 cycle, ack_0/1/3 stay 0, req__valid low the next cycle.
- All four ports valid at once, engine acks immediately, each requester drops after its ack.
  - Required: grant order 0,1,2,3.
  - Required: req__address sequence 1010, 2010, 3010, 4010, each spaced 2 cycles.
- Ports 1 and 3 continuously re-requesting after each ack.
  - Required: grants alternate 1,3,1,3.
  - Required: port 3 never waits more than one port-1 grant.
- Engine ack delayed 5 cycles; port 0 changes data_0 after its ack_0.
  - Required: req__* stays bit-identical and busy=1 for all 5 cycles.
  - Required: no ack_N during BUSY, and the new port 0 data is not forwarded.
- reset_n asserted mid-BUSY while port 3 is granted and port 1 is waiting.
  - Required: req__valid=0 and busy=0 immediately.
  - Required: after release, port 1 is granted first and last_grant=1.
- clk__enable low for 3 cycles during an ack_2 pulse.
  - Required: ack_2 stays high across the disabled cycles and drops after the next enabled edge.
